// File: rtl/alu_exec.sv
// alu_exec: RV32I execute stage sitting directly downstream of the register file.
//   Accepts two operands plus a decoded op and computes the ALU result. It holds the
//   result until the consumer takes it and drives the register-file write port.
//   Shifts are iterative, moving at most SHIFT_STEP bits per cycle. All other ops
//   complete in a single cycle.
// Ports:
//   clkin, rst_in                 clock (rising edge), async active-high reset
//   in_valid / in_ready           input handshake; in_ready is high only in IDLE
//   op_in                         {funct7[5], funct3}
//   op1_in, op2_in, rd_idx_in     operands and destination register index
//   out_valid / out_ready         output handshake
//   out_result, out_rd_idx        held result and its destination index
//   wr_en_out                     register-file write strobe (suppressed for x0)
module alu_exec #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned SHIFT_STEP = 1
) (
   input  logic            clkin,
   input  logic            rst_in,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op_in,
   input  logic [XLEN-1:0] op1_in,
   input  logic [XLEN-1:0] op2_in,
   input  logic [4:0]      rd_idx_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd_idx,
   output logic            wr_en_out
);

   localparam logic [3:0] OpAdd  = 4'b0000;
   localparam logic [3:0] OpSub  = 4'b1000;
   localparam logic [3:0] OpSll  = 4'b0001;
   localparam logic [3:0] OpSlt  = 4'b0010;
   localparam logic [3:0] OpSltu = 4'b0011;
   localparam logic [3:0] OpXor  = 4'b0100;
   localparam logic [3:0] OpSrl  = 4'b0101;
   localparam logic [3:0] OpSra  = 4'b1101;
   localparam logic [3:0] OpOr   = 4'b0110;
   localparam logic [3:0] OpAnd  = 4'b0111;

   localparam logic [4:0] StepW = 5'(SHIFT_STEP);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q;
   logic [XLEN-1:0] acc_q;    // shift accumulator, and the held result in DONE
   logic [4:0]      count_q;  // remaining shift distance
   logic [3:0]      op_q;     // shift kind latched on accept
   logic [4:0]      rd_q;

   logic [XLEN-1:0] alu_d;
   logic [XLEN-1:0] shift_d;
   logic [4:0]      step;
   logic [4:0]      shamt;
   logic            is_shift;

   assign shamt    = op2_in[4:0];
   assign is_shift = (op_in == OpSll) || (op_in == OpSrl) || (op_in == OpSra);

   // Single-cycle results. A shift lands here only when shamt is 0, so it passes op1 through.
   always_comb begin
      alu_d = '0;
      case (op_in)
         OpAdd:                alu_d = op1_in + op2_in;
         OpSub:                alu_d = op1_in - op2_in;
         OpSlt:                alu_d = XLEN'($signed(op1_in) < $signed(op2_in));
         OpSltu:               alu_d = XLEN'(op1_in < op2_in);
         OpXor:                alu_d = op1_in ^ op2_in;
         OpOr:                 alu_d = op1_in | op2_in;
         OpAnd:                alu_d = op1_in & op2_in;
         OpSll, OpSrl, OpSra:  alu_d = op1_in;
         default:              alu_d = '0;
      endcase
   end

   // One iteration of the shifter: move by min(SHIFT_STEP, remaining).
   always_comb begin
      step    = (count_q < StepW) ? count_q : StepW;
      shift_d = acc_q;
      case (op_q)
         OpSll:   shift_d = acc_q << step;
         OpSrl:   shift_d = acc_q >> step;
         default: shift_d = $signed(acc_q) >>> step;
      endcase
   end

   always_ff @(posedge clkin or posedge rst_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         acc_q   <= '0;
         count_q <= '0;
         op_q    <= '0;
         rd_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  rd_q <= rd_idx_in;
                  if (is_shift && (shamt != 5'd0)) begin
                     acc_q   <= op1_in;
                     count_q <= shamt;
                     op_q    <= op_in;
                     state_q <= StShift;
                  end else begin
                     acc_q   <= alu_d;
                     state_q <= StDone;
                  end
               end
            end
            StShift: begin
               acc_q   <= shift_d;
               count_q <= count_q - step;
               if (count_q == step) state_q <= StDone;
            end
            StDone: begin
               if (out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Gate with reset so the stage never advertises readiness while held in reset.
   assign in_ready   = (state_q == StIdle) && !rst_in;
   assign out_valid  = (state_q == StDone);
   assign out_result = acc_q;
   assign out_rd_idx = rd_q;
   assign wr_en_out  = out_valid && out_ready && (rd_q != 5'd0);

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

   localparam int unsigned STEP = 1;

   logic        clkin = 1'b0;
   logic        rst_in = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op_in = '0;
   logic [31:0] op1_in = '0;
   logic [31:0] op2_in = '0;
   logic [4:0]  rd_idx_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic [4:0]  out_rd_idx;
   logic        wr_en_out;

   int total = 0;
   int bad = 0;

   alu_exec #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
      .clkin      (clkin),
      .rst_in     (rst_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_in      (op_in),
      .op1_in     (op1_in),
      .op2_in     (op2_in),
      .rd_idx_in  (rd_idx_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd_idx (out_rd_idx),
      .wr_en_out  (wr_en_out)
   );

   always #5 clkin = ~clkin;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference behaviour straight from the RV32I definitions.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, b);
      int unsigned sh;
      sh = b[4:0];
      case (op)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << sh;
         4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> sh;
         4'b1101: return $signed(a) >>> sh;
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int exp_latency(input logic [3:0] op, input logic [4:0] sh);
      if (!(op == 4'b0001 || op == 4'b0101 || op == 4'b1101) || sh == 5'd0) return 1;
      return 1 + (int'(sh) + int'(STEP) - 1) / int'(STEP);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op with out_ready held high and check latency, result and write port.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      logic [31:0] exp;
      int          exp_lat;
      int          lat;
      int          wait_n;
      exp     = model(op, a, b);
      exp_lat = exp_latency(op, b[4:0]);
      out_ready = 1'b1;
      @(negedge clkin);
      wait_n = 0;
      while (!in_ready && wait_n < 50) begin
         @(negedge clkin);
         wait_n++;
      end
      check("in_ready_before_op", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      op_in     = op;
      op1_in    = a;
      op2_in    = b;
      rd_idx_in = rd;
      @(posedge clkin);
      #1;
      in_valid = 1'b0;
      op1_in   = $urandom;
      op2_in   = $urandom;
      lat = 1;
      @(negedge clkin);
      while (!out_valid && lat < 100) begin
         @(negedge clkin);
         lat++;
      end
      check($sformatf("latency op=%b sh=%0d", op, b[4:0]), 32'(lat), 32'(exp_lat));
      check($sformatf("result op=%b a=%h b=%h", op, a, b), out_result, exp);
      check("rd_idx", 32'(out_rd_idx), 32'(rd));
      check("wr_en", 32'(wr_en_out), (rd != 5'd0) ? 32'd1 : 32'd0);
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      @(posedge clkin);
      #1;
      check("valid_drop_after_hs", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      // Reset values while reset is asserted
      #2 rst_in = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_rd_idx", 32'(out_rd_idx), 32'd0);
      check("rst_wr_en", 32'(wr_en_out), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clkin);
      rst_in = 1'b0;
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Directed cases
      do_op(4'b0000, 32'd5, 32'd7, 5'd3);
      do_op(4'b1000, 32'd0, 32'd1, 5'd4);
      do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd5);
      do_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd6);
      do_op(4'b1101, 32'h8000_0000, 32'd31, 5'd7);
      do_op(4'b0101, 32'h8000_0000, 32'd31, 5'd8);
      do_op(4'b0001, 32'h0000_0001, 32'd0, 5'd9);
      do_op(4'b0001, 32'h0000_0001, 32'hFFFF_FFE4, 5'd10);  // upper shamt bits ignored
      do_op(4'b0000, 32'd11, 32'd22, 5'd0);                 // write to x0 suppressed
      do_op(4'b1001, 32'd11, 32'd22, 5'd12);                // undefined op

      // Backpressure: hold DONE for 10 cycles while offering a competing op
      @(negedge clkin);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op_in     = 4'b0100;
      op1_in    = 32'hF0F0_1234;
      op2_in    = 32'h0FF0_4321;
      rd_idx_in = 5'd9;
      @(posedge clkin);
      #1;
      in_valid = 1'b0;
      held = model(4'b0100, 32'hF0F0_1234, 32'h0FF0_4321);
      for (int i = 0; i < 10; i++) begin
         @(posedge clkin);
         #1;
         in_valid  = 1'b1;
         op_in     = 4'b0000;
         op1_in    = $urandom;
         op2_in    = $urandom;
         rd_idx_in = 5'd17;
         @(negedge clkin);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_result", out_result, held);
         check("bp_rd", 32'(out_rd_idx), 32'd9);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_wr_en", 32'(wr_en_out), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp_release_wr_en", 32'(wr_en_out), 32'd1);
      @(posedge clkin);
      #1;
      check("bp_after_hs_valid", 32'(out_valid), 32'd0);
      check("bp_after_hs_in_ready", 32'(in_ready), 32'd1);
      @(negedge clkin);
      check("bp_no_ghost_op", 32'(out_valid), 32'd0);

      // Reset in the middle of a 20-bit shift
      @(negedge clkin);
      in_valid  = 1'b1;
      op_in     = 4'b0001;
      op1_in    = 32'h0000_0003;
      op2_in    = 32'd20;
      rd_idx_in = 5'd21;
      @(posedge clkin);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clkin);
      #1;
      rst_in = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_result", out_result, 32'd0);
      check("midrst_rd", 32'(out_rd_idx), 32'd0);
      check("midrst_wr_en", 32'(wr_en_out), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clkin);
      rst_in = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clkin);
         check("post_rst_no_wr", 32'(wr_en_out), 32'd0);
         check("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      do_op(4'b0000, 32'd100, 32'd23, 5'd1);

      // Randomized ops against the reference model
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 5) == 0) rb[4:0] = 5'd0;
         do_op(rop, ra, rb, 5'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
